// File: rtl/router_arb_pkg.sv
// router_arb_pkg
// Shared types and helpers for the router allocators.
//   arb_state_e : output-port arbiter FSM state encoding
//   cnt_width() : bits needed to hold a credit count from 0 to depth
package router_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if
// Bundles the request side and status side of one router output port.
//   req/is_tail/turn_disable : per-input request, tail marker, turn restriction
//   credit_in                : downstream freed one buffer slot
//   grant/grant_idx/send_out : same-cycle selection of the winning input
//   credits/locked           : current credit count and packet-in-progress
//   credit_overflow          : sticky error, credit returned while full
// master drives the requests (router input side), slave is the arbiter.
interface output_port_arbiter_if
    import router_arb_pkg::*;
#(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 8
);
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int CNT_W = cnt_width(FLIT_BUFFER_DEPTH);

    logic [NUM_INPUTS-1:0] req;
    logic [NUM_INPUTS-1:0] is_tail;
    logic [NUM_INPUTS-1:0] turn_disable;
    logic                  credit_in;
    logic [NUM_INPUTS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  send_out;
    logic [CNT_W-1:0]      credits;
    logic                  locked;
    logic                  credit_overflow;

    modport master (
        output req, is_tail, turn_disable, credit_in,
        input  grant, grant_idx, send_out, credits, locked, credit_overflow
    );

    modport slave (
        input  req, is_tail, turn_disable, credit_in,
        output grant, grant_idx, send_out, credits, locked, credit_overflow
    );
endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
// Circular first-set search: picks the first asserted bit of req starting
// one position after ptr and wrapping past N-1 back to 0.
//   req   : request vector
//   ptr   : last winner; it gets lowest priority
//   grant : one-hot winner, all zero when req is zero
//   idx   : binary index of the winner, 0 when none
module rr_priority_picker #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);
    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter
// Wormhole output-port arbiter with credit-based flow control. Packets are
// granted round-robin among eligible inputs; once a multi-flit packet starts,
// the port stays locked to its owner until the tail flit leaves.
//   clk_noc : NoC clock
//   rst_n   : synchronous active-low reset
//   bus     : slave side of output_port_arbiter_if
//
// state      | meaning
// ARB_IDLE   | no packet in flight, round-robin among eligible inputs
// ARB_LOCKED | packet in flight, only the owner may send
module output_port_arbiter
    import router_arb_pkg::*;
#(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 8
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    output_port_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int CNT_W = cnt_width(FLIT_BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FLIT_BUFFER_DEPTH);

    arb_state_e            state;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  overflow;

    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_INPUTS-1:0] grant_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  send;
    logic                  tail_sent;

    assign eligible = bus.req & ~bus.turn_disable;

    rr_priority_picker #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Uses the registered cnt only, so a credit arriving this cycle cannot
    // enable a grant until the next one.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        if (rst_n && (cnt != '0)) begin
            if (state == ARB_IDLE) begin
                grant_c = pick_grant;
                idx_c   = pick_idx;
            end else if (bus.req[owner]) begin
                grant_c[owner] = 1'b1;
                idx_c          = owner;
            end
        end
    end

    assign send      = |grant_c;
    assign tail_sent = send && bus.is_tail[idx_c];

    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= IDX_W'(NUM_INPUTS - 1);
            cnt      <= CNT_FULL;
            overflow <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (send && !tail_sent) begin
                        state <= ARB_LOCKED;
                        owner <= idx_c;
                    end else if (tail_sent) begin
                        rr_ptr <= idx_c;
                    end
                end
                ARB_LOCKED: begin
                    if (tail_sent) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= owner;
                    end
                end
                default: state <= ARB_IDLE;
            endcase

            if (send && !bus.credit_in) begin
                cnt <= cnt - CNT_W'(1);
            end else if (!send && bus.credit_in) begin
                if (cnt == CNT_FULL) begin
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.grant           = grant_c;
    assign bus.grant_idx       = idx_c;
    assign bus.send_out        = send;
    assign bus.credits         = cnt;
    assign bus.locked          = (state == ARB_LOCKED);
    assign bus.credit_overflow = overflow;
endmodule
